snake_pixel_gen: RTL and testbench



---
 rtl/snake_pkg.sv | 45 ++++
 rtl/snake_pixel_gen_if.sv | 26 ++
 rtl/snake_body.sv | 55 +++++
 rtl/snake_pixel_gen.sv | 129 ++++++++++++
 tb/tb_snake_pixel_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game pixel stage.
// The playfield is an 80x60 grid of 8x8-pixel cells.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  localparam int GRID_W     = 80;
  localparam int GRID_H     = 60;
  localparam int CELL_SHIFT = 3;
  localparam int X_W        = 7;
  localparam int Y_W        = 6;
  localparam int CELL_W     = X_W + Y_W;

  localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [9:0]     PIX_W   = 10'(GRID_W << CELL_SHIFT);
  localparam logic [9:0]     PIX_H   = 10'(GRID_H << CELL_SHIFT);

  localparam logic [11:0] HEAD    = 12'hFF0;
  localparam logic [11:0] BODY    = 12'h0F0;
  localparam logic [11:0] TARGET  = 12'hF00;
  localparam logic [11:0] BG_PLAY = 12'h00F;
  localparam logic [11:0] BG_DEAD = 12'h800;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  // Opposite headings differ only in bit 1 of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_pixel_gen_if.sv
// Game-control and pixel-address bundle between the game stage and its
// neighbours (controller side as master, game stage as slave).
interface snake_pixel_gen_if #(
  parameter int LEN_W = 5
);
  logic             TICK;
  logic [1:0]       DIR;
  logic [6:0]       TARGET_X;
  logic [5:0]       TARGET_Y;
  logic [9:0]       ADDRE;
  logic [9:0]       ADDRV;
  logic [11:0]      COLOUR_OUT;
  logic             TARGET_HIT;
  logic             DEAD;
  logic [LEN_W-1:0] LENGTH;

  modport master (
    output TICK, DIR, TARGET_X, TARGET_Y, ADDRE, ADDRV,
    input  COLOUR_OUT, TARGET_HIT, DEAD, LENGTH
  );

  modport slave (
    input  TICK, DIR, TARGET_X, TARGET_Y, ADDRE, ADDRV,
    output COLOUR_OUT, TARGET_HIT, DEAD, LENGTH
  );
endinterface

// File: rtl/snake_body.sv
// Segment shift register (head at index 0) and the live segment count.
// Growing needs no special path: the full-depth shift keeps the old tail.
module snake_body
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int LEN_W    = 5,
  parameter int START_X  = 40,
  parameter int START_Y  = 30
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      shift_en,
  input  logic                      grow_en,
  input  cell_t                     next_head,
  output logic [MAX_LEN*CELL_W-1:0] segs_flat,
  output logic [LEN_W-1:0]          length
);

  cell_t [MAX_LEN-1:0] seg_q, seg_d, seg_init;
  logic  [LEN_W-1:0]   length_q, length_d;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
    assign seg_init[gi] = {X_W'(START_X - gi), Y_W'(START_Y)};
  end

  always_comb begin
    seg_d    = seg_q;
    length_d = length_q;
    if (shift_en) begin
      seg_d[0] = next_head;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_d[i] = seg_q[i-1];
      end
      if (grow_en && (length_q != LEN_W'(MAX_LEN))) begin
        length_d = length_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      seg_q    <= seg_init;
      length_q <= LEN_W'(INIT_LEN);
    end else begin
      seg_q    <= seg_d;
      length_q <= length_d;
    end
  end

  assign segs_flat = seg_q;
  assign length    = length_q;

endmodule

// File: rtl/snake_pixel_gen.sv
// Snake game state (heading, PLAY/DEAD, collisions) and the registered
// per-pixel colour fed to the VGA timing block.
module snake_pixel_gen
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int LEN_W    = 5,
  parameter int START_X  = 40,
  parameter int START_Y  = 30
) (
  input logic               CLK,
  input logic               RESET,
  snake_pixel_gen_if.slave  bus
);

  state_t                    state_q;
  dir_t                      heading_q, heading_d, dir_req, dir_eff;
  logic                      target_hit_q, dead_q;
  logic [11:0]               colour_q, colour_d, bg_colour;
  cell_t                     head, next_head, target_cell, pix_cell;
  logic [MAX_LEN*CELL_W-1:0] segs_flat;
  logic [LEN_W-1:0]          length;
  logic [MAX_LEN-1:0]        coll_vec, body_vec;
  logic                      collide, eat, step, pix_in_range;

  assign dir_req     = dir_t'(bus.DIR);
  assign head        = cell_t'(segs_flat[CELL_W-1:0]);
  assign target_cell = {bus.TARGET_X, bus.TARGET_Y};

  // A reverse request would fold the head straight back into the body.
  always_comb begin
    dir_eff   = (dir_req == reverse_dir(heading_q)) ? heading_q : dir_req;
    heading_d = (state_q == ST_PLAY) ? dir_eff : heading_q;
  end

  always_comb begin
    next_head = head;
    unique case (dir_eff)
      DIR_UP:    next_head.y = (head.y == '0)    ? Y_MAX : head.y - 1'b1;
      DIR_RIGHT: next_head.x = (head.x == X_MAX) ? '0    : head.x + 1'b1;
      DIR_DOWN:  next_head.y = (head.y == Y_MAX) ? '0    : head.y + 1'b1;
      DIR_LEFT:  next_head.x = (head.x == '0)    ? X_MAX : head.x - 1'b1;
    endcase
  end

  assign pix_in_range = (bus.ADDRE < PIX_W) && (bus.ADDRV < PIX_H);
  assign pix_cell     = {X_W'(bus.ADDRE >> CELL_SHIFT), Y_W'(bus.ADDRV >> CELL_SHIFT)};

  // The current tail vacates its cell on this step, so it is excluded.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
    cell_t seg;
    assign seg          = cell_t'(segs_flat[gi*CELL_W +: CELL_W]);
    assign coll_vec[gi] = (gi < int'(length) - 1) && (seg == next_head);
    assign body_vec[gi] = (gi != 0) && (gi < int'(length)) && (seg == pix_cell);
  end

  assign collide = |coll_vec;
  assign eat     = (next_head == target_cell);
  assign step    = bus.TICK && (state_q == ST_PLAY);

  snake_body #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN),
    .LEN_W    (LEN_W),
    .START_X  (START_X),
    .START_Y  (START_Y)
  ) u_body (
    .clk       (CLK),
    .srst      (RESET),
    .shift_en  (step && !collide),
    .grow_en   (eat),
    .next_head (next_head),
    .segs_flat (segs_flat),
    .length    (length)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_PLAY;
      dead_q       <= 1'b0;
      target_hit_q <= 1'b0;
    end else begin
      target_hit_q <= 1'b0;
      case (state_q)
        ST_PLAY: begin
          if (bus.TICK) begin
            if (collide) begin
              state_q <= ST_DEAD;
              dead_q  <= 1'b1;
            end else begin
              target_hit_q <= eat;
            end
          end
        end
        ST_DEAD: begin
          dead_q <= 1'b1;
        end
        default: state_q <= ST_PLAY;
      endcase
    end
  end

  always_comb begin
    bg_colour = (state_q == ST_DEAD) ? BG_DEAD : BG_PLAY;
    colour_d  = bg_colour;
    if (pix_in_range) begin
      if (head == pix_cell)             colour_d = HEAD;
      else if (|body_vec)               colour_d = BODY;
      else if (target_cell == pix_cell) colour_d = TARGET;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      heading_q <= DIR_RIGHT;
      colour_q  <= 12'h000;
    end else begin
      heading_q <= heading_d;
      colour_q  <= colour_d;
    end
  end

  assign bus.COLOUR_OUT = colour_q;
  assign bus.TARGET_HIT = target_hit_q;
  assign bus.DEAD       = dead_q;
  assign bus.LENGTH     = length;

endmodule

// File: tb/tb_snake_pixel_gen.sv
// Self-checking bench for snake_pixel_gen: scenario tasks with a colour
// scoreboard filled as pixel addresses are driven and drained one cycle later.
module tb_snake_pixel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] sb_q[$];

  snake_pixel_gen_if #(.LEN_W(5)) bus();

  snake_pixel_gen #(
    .MAX_LEN(16), .INIT_LEN(4), .LEN_W(5), .START_X(40), .START_Y(30)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.TICK = 1'b0;
    bus.DIR = 2'd1;
    bus.TARGET_X = 7'd5;
    bus.TARGET_Y = 6'd5;
    bus.ADDRE = 10'd0;
    bus.ADDRV = 10'd0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic tick(input logic [1:0] d);
    bus.DIR = d;
    bus.TICK = 1'b1;
    cyc();
    bus.TICK = 1'b0;
  endtask

  task automatic set_target(input int x, input int y);
    bus.TARGET_X = 7'(x);
    bus.TARGET_Y = 6'(y);
  endtask

  // Drive a pixel inside cell (cx,cy), varying the in-cell offset with k.
  task automatic drive_cell(input int cx, input int cy, input int k, input logic [11:0] exp);
    bus.ADDRE = 10'(cx * 8 + (k & 7));
    bus.ADDRV = 10'(cy * 8 + ((k * 3) & 7));
    sb_q.push_back(exp);
  endtask

  task automatic test_reset();
    int          cx[7] = '{40, 39, 37, 36, 5, 80, 10};
    int          cy[7] = '{30, 30, 30, 30, 5, 30, 60};
    logic [11:0] ex[7] = '{12'hFF0, 12'h0F0, 12'h0F0, 12'h00F, 12'hF00, 12'h00F, 12'h00F};
    logic [11:0] exp_c;
    rst = 1'b1;
    bus.TICK = 1'b0; bus.DIR = 2'd1; bus.ADDRE = 10'd0; bus.ADDRV = 10'd0;
    set_target(5, 5);
    cyc();
    cyc();
    checks++;
    if (bus.COLOUR_OUT !== 12'h000) begin failures++; $display("FAIL reset_colour got=%h want=000", bus.COLOUR_OUT); end
    checks++;
    if (bus.LENGTH !== 5'd4) begin failures++; $display("FAIL reset_length got=%0d want=4", bus.LENGTH); end
    checks++;
    if (bus.DEAD !== 1'b0 || bus.TARGET_HIT !== 1'b0) begin
      failures++; $display("FAIL reset_flags dead=%b hit=%b want=0,0", bus.DEAD, bus.TARGET_HIT);
    end
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_cell(cx[k], cy[k], k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL reset_pix cell(%0d,%0d) got=%h want=%h", cx[k], cy[k], bus.COLOUR_OUT, exp_c);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_move_reverse();
    int          cx[5] = '{42, 41, 39, 38, 43};
    logic [11:0] ex[5] = '{12'hFF0, 12'h0F0, 12'h0F0, 12'h00F, 12'h00F};
    logic [11:0] exp_c;
    do_reset();
    tick(2'd1);
    checks++;
    if (bus.LENGTH !== 5'd4) begin failures++; $display("FAIL move_length got=%0d want=4", bus.LENGTH); end
    bus.ADDRE = 10'd328; bus.ADDRV = 10'd240;
    sb_q.push_back(12'hFF0);
    cyc();
    exp_c = sb_q.pop_front();
    checks++;
    if (bus.COLOUR_OUT !== exp_c) begin failures++; $display("FAIL move_head_pix got=%h want=%h", bus.COLOUR_OUT, exp_c); end
    tick(2'd3);
    for (int k = 0; k < 5; k++) begin
      drive_cell(cx[k], 30, k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL reverse_pix cell(%0d,30) got=%h want=%h", cx[k], bus.COLOUR_OUT, exp_c);
      end
    end
    $display("move_reverse: done");
  endtask

  task automatic test_wrap();
    int          cx[7] = '{0, 79, 77, 76, 40, 40, 40};
    int          cy[7] = '{30, 30, 30, 30, 59, 0, 58};
    logic [11:0] ex[7] = '{12'hFF0, 12'h0F0, 12'h0F0, 12'h00F, 12'hFF0, 12'h0F0, 12'h00F};
    logic [11:0] exp_c;
    do_reset();
    repeat (40) tick(2'd1);
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        do_reset();
        repeat (31) tick(2'd0);
      end
      drive_cell(cx[k], cy[k], k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL wrap_pix cell(%0d,%0d) got=%h want=%h", cx[k], cy[k], bus.COLOUR_OUT, exp_c);
      end
    end
    $display("wrap: done");
  endtask

  task automatic test_target_hit();
    int          cx[5] = '{41, 40, 37, 36, 5};
    int          cy[5] = '{30, 30, 30, 30, 5};
    logic [11:0] ex[5] = '{12'hFF0, 12'h0F0, 12'h0F0, 12'h00F, 12'hF00};
    logic [11:0] exp_c;
    do_reset();
    set_target(41, 30);
    tick(2'd1);
    checks++;
    if (bus.TARGET_HIT !== 1'b1) begin failures++; $display("FAIL hit_pulse got=%b want=1", bus.TARGET_HIT); end
    checks++;
    if (bus.LENGTH !== 5'd5) begin failures++; $display("FAIL hit_length got=%0d want=5", bus.LENGTH); end
    set_target(5, 5);
    cyc();
    checks++;
    if (bus.TARGET_HIT !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b want=0", bus.TARGET_HIT); end
    for (int k = 0; k < 5; k++) begin
      drive_cell(cx[k], cy[k], k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL hit_pix cell(%0d,%0d) got=%h want=%h", cx[k], cy[k], bus.COLOUR_OUT, exp_c);
      end
    end
    $display("target_hit: done");
  endtask

  task automatic test_self_collision();
    int          cx[6] = '{40, 41, 10, 5, 40, 40};
    int          cy[6] = '{31, 31, 10, 5, 31, 32};
    logic [11:0] ex[6] = '{12'hFF0, 12'h0F0, 12'h800, 12'hF00, 12'hFF0, 12'h800};
    logic [11:0] exp_c;
    do_reset();
    set_target(41, 30);
    tick(2'd1);
    set_target(5, 5);
    tick(2'd2);
    tick(2'd3);
    tick(2'd0);
    checks++;
    if (bus.DEAD !== 1'b1) begin failures++; $display("FAIL dead_flag got=%b want=1", bus.DEAD); end
    checks++;
    if (bus.TARGET_HIT !== 1'b0 || bus.LENGTH !== 5'd5) begin
      failures++; $display("FAIL dead_hit_len hit=%b len=%0d want=0,5", bus.TARGET_HIT, bus.LENGTH);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        tick(2'd2);
        tick(2'd2);
      end
      drive_cell(cx[k], cy[k], k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL dead_pix cell(%0d,%0d) got=%h want=%h", cx[k], cy[k], bus.COLOUR_OUT, exp_c);
      end
    end
    checks++;
    if (bus.DEAD !== 1'b1) begin failures++; $display("FAIL dead_sticky got=%b want=1", bus.DEAD); end
    $display("self_collision: done");
  endtask

  task automatic test_max_len();
    int          cx[7] = '{53, 38, 37, 40, 37, 41, 53};
    logic [11:0] ex[7] = '{12'hFF0, 12'h0F0, 12'h00F, 12'hFF0, 12'h0F0, 12'h00F, 12'h00F};
    logic [11:0] exp_c;
    int          want_len;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      set_target(41 + k, 30);
      tick(2'd1);
      want_len = (5 + k > 16) ? 16 : 5 + k;
      checks++;
      if (bus.TARGET_HIT !== 1'b1 || bus.LENGTH !== 5'(want_len)) begin
        failures++; $display("FAIL grow_%0d hit=%b len=%0d want=1,%0d", k, bus.TARGET_HIT, bus.LENGTH, want_len);
      end
    end
    set_target(5, 5);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        rst = 1'b1;
        bus.TICK = 1'b1;
        set_target(54, 30);
        cyc();
        bus.TICK = 1'b0;
        rst = 1'b0;
        set_target(5, 5);
        checks++;
        if (bus.LENGTH !== 5'd4 || bus.DEAD !== 1'b0 || bus.TARGET_HIT !== 1'b0 || bus.COLOUR_OUT !== 12'h000) begin
          failures++;
          $display("FAIL reset_tick len=%0d dead=%b hit=%b colour=%h want=4,0,0,000",
                   bus.LENGTH, bus.DEAD, bus.TARGET_HIT, bus.COLOUR_OUT);
        end
      end
      drive_cell(cx[k], 30, k, ex[k]);
      cyc();
      exp_c = sb_q.pop_front();
      checks++;
      if (bus.COLOUR_OUT !== exp_c) begin
        failures++; $display("FAIL maxlen_pix cell(%0d,30) got=%h want=%h", cx[k], bus.COLOUR_OUT, exp_c);
      end
    end
    $display("max_len: done");
  endtask

  initial begin
    test_reset();
    test_move_reverse();
    test_wrap();
    test_target_hit();
    test_self_collision();
    test_max_len();
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
